// File: rtl/block_b_requester_if.sv
// Bundle of the requester's control and DataRequest/Ack handshake signals.
// The master modport is the requester side; the slave modport is the responder/controller side.
interface block_b_requester_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
);
   logic             Start;
   logic [CNT_W-1:0] BurstLen;
   logic             Ack;
   logic [WIDTH-1:0] Data;
   logic             DataRequest;
   logic [WIDTH-1:0] DataOut;
   logic             DataValid;
   logic             Busy;
   logic             Done;
   logic             Error;
   logic [CNT_W-1:0] WordCount;

   modport master (
      input  Start, BurstLen, Ack, Data,
      output DataRequest, DataOut, DataValid, Busy, Done, Error, WordCount
   );

   modport slave (
      output Start, BurstLen, Ack, Data,
      input  DataRequest, DataOut, DataValid, Busy, Done, Error, WordCount
   );
endinterface

// File: rtl/block_b_requester.sv
// Four-phase DataRequest/Ack burst initiator with a per-phase timeout.
// Captures one word per handshake and flags a dead responder with a sticky Error.
module block_b_requester #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned CNT_W   = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                Clk,
   input  logic                ResetN,
   block_b_requester_if.master bus
);
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_REL  = 2'd2,
      S_ERR  = 2'd3
   } state_e;

   state_e           state_q;
   logic [TMO_W-1:0] tmo_q;
   logic [TMO_W-1:0] tmo_d;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] wc_q;
   logic [CNT_W-1:0] wc_d;
   logic [WIDTH-1:0] dout_q;
   logic             req_q;
   logic             dv_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic             start_ok;

   assign tmo_d = tmo_q + TMO_W'(1);
   // Count saturates at the latched burst length.
   assign wc_d  = (wc_q == len_q) ? wc_q : wc_q + CNT_W'(1);

   // A Start in ERR is only honoured once the responder has released Ack.
   assign start_ok = bus.Start &&
                     ((state_q == S_IDLE) || ((state_q == S_ERR) && !bus.Ack));

   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         state_q <= S_IDLE;
         tmo_q   <= '0;
         len_q   <= '0;
         wc_q    <= '0;
         dout_q  <= '0;
         req_q   <= 1'b0;
         dv_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         dv_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_ERR: begin
               if (start_ok) begin
                  err_q <= 1'b0;
                  wc_q  <= '0;
                  tmo_q <= '0;
                  if (bus.BurstLen != '0) begin
                     len_q   <= bus.BurstLen;
                     req_q   <= 1'b1;
                     busy_q  <= 1'b1;
                     state_q <= S_REQ;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end
            end
            S_REQ: begin
               if (bus.Ack) begin
                  dout_q  <= bus.Data;
                  dv_q    <= 1'b1;
                  wc_q    <= wc_d;
                  req_q   <= 1'b0;
                  tmo_q   <= '0;
                  state_q <= S_REL;
               end else if (tmo_q == TMO_LAST) begin
                  req_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= S_ERR;
               end else begin
                  tmo_q <= tmo_d;
               end
            end
            S_REL: begin
               if (!bus.Ack) begin
                  if (wc_q == len_q) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     req_q   <= 1'b1;
                     tmo_q   <= '0;
                     state_q <= S_REQ;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= S_ERR;
               end else begin
                  tmo_q <= tmo_d;
               end
            end
            default: begin
               req_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.DataRequest = req_q;
   assign bus.DataOut     = dout_q;
   assign bus.DataValid   = dv_q;
   assign bus.Busy        = busy_q;
   assign bus.Done        = done_q;
   assign bus.Error       = err_q;
   assign bus.WordCount   = wc_q;
endmodule

// File: tb/tb_block_b_requester.sv
// Bench for block_b_requester: table of bursts against an auto-acking responder,
// plus hand-written timeout, stuck-Ack and mid-burst reset sequences.
module tb_block_b_requester;
   localparam int unsigned WIDTH   = 8;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned TIMEOUT = 15;

   logic Clk = 1'b0;
   logic ResetN;
   always #5 Clk = ~Clk;

   block_b_requester_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   block_b_requester #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .Clk    (Clk),
      .ResetN (ResetN),
      .bus    (bus)
   );

   typedef struct {
      logic [CNT_W-1:0] len;
      logic [31:0]      words;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int done_cnt = 0;
   int dv_cnt = 0;
   int req_cnt = 0;
   int done_cyc = -1;
   int start_cyc = 0;
   int err_cyc = 0;
   bit resp_auto = 1'b0;
   logic [WIDTH-1:0] sb_q[$];
   logic [WIDTH-1:0] resp_q[$];
   logic [WIDTH-1:0] resp_w;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor and responder: sample outputs on the falling edge, then answer the handshake.
   initial begin
      forever begin
         @(negedge Clk);
         cyc++;
         if (bus.DataValid === 1'b1) begin
            dv_cnt++;
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL dataout_unexpected: got %0h, expected no DataValid", bus.DataOut);
            end else begin
               check("dataout", 32'(bus.DataOut), 32'(sb_q.pop_front()));
            end
         end
         if (bus.Done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_dv_exclusive", 32'(bus.DataValid), 32'd0);
         end
         if (bus.DataRequest === 1'b1) req_cnt++;
         if (resp_auto) begin
            if (bus.DataRequest === 1'b1 && !bus.Ack) begin
               resp_w = (resp_q.size() != 0) ? resp_q.pop_front() : '0;
               bus.Data = resp_w;
               sb_q.push_back(resp_w);
               bus.Ack = 1'b1;
            end else if (bus.DataRequest !== 1'b1) begin
               bus.Ack = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(negedge Clk);
      #1;
   endtask

   task automatic start_burst(input logic [CNT_W-1:0] len);
      tick();
      bus.Start    = 1'b1;
      bus.BurstLen = len;
      start_cyc    = cyc;
      tick();
      bus.Start    = 1'b0;
      bus.BurstLen = ~len;
   endtask

   task automatic wait_done(input int base, input int budget, output bit ok);
      int n = 0;
      while (done_cnt == base && n < budget) begin
         tick();
         n++;
      end
      ok = (done_cnt > base);
   endtask

   task automatic wait_err(input int budget, output bit ok);
      int n = 0;
      while (bus.Error !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      ok = (bus.Error === 1'b1);
      err_cyc = cyc;
   endtask

   initial begin
      vec_t vecs[5];
      bit ok;
      int base_done, base_dv, base_req, ack_cyc;

      vecs[0] = '{len: 4'd3, words: 32'h00FF3CA5};
      vecs[1] = '{len: 4'd0, words: 32'h00000000};
      vecs[2] = '{len: 4'd1, words: 32'h0000005A};
      vecs[3] = '{len: 4'd4, words: 32'h04030201};
      vecs[4] = '{len: 4'd2, words: 32'h00007F80};

      // Reset held two cycles with Start asserted.
      ResetN = 1'b0;
      bus.Start = 1'b1;
      bus.BurstLen = 4'd3;
      bus.Ack = 1'b0;
      bus.Data = '0;
      tick();
      tick();
      check("rst_datarequest", 32'(bus.DataRequest), 32'd0);
      check("rst_busy", 32'(bus.Busy), 32'd0);
      check("rst_error", 32'(bus.Error), 32'd0);
      check("rst_wordcount", 32'(bus.WordCount), 32'd0);
      check("rst_dataout", 32'(bus.DataOut), 32'd0);
      check("rst_done", 32'(bus.Done), 32'd0);
      bus.Start = 1'b0;
      ResetN = 1'b1;
      tick();

      // Table of bursts against the auto responder.
      resp_auto = 1'b1;
      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < int'(vecs[i].len); k++) resp_q.push_back(vecs[i].words[8*k +: 8]);
         base_done = done_cnt;
         base_dv   = dv_cnt;
         base_req  = req_cnt;
         start_burst(vecs[i].len);
         wait_done(base_done, 200, ok);
         check($sformatf("v%0d_done_seen", i), 32'(ok), 32'd1);
         if (vecs[i].len == '0) begin
            check($sformatf("v%0d_done_latency", i), 32'(done_cyc - start_cyc), 32'd1);
            check($sformatf("v%0d_no_request", i), 32'(req_cnt - base_req), 32'd0);
         end
         repeat (3) tick();
         check($sformatf("v%0d_done_once", i), 32'(done_cnt - base_done), 32'd1);
         check($sformatf("v%0d_dv_count", i), 32'(dv_cnt - base_dv), 32'(vecs[i].len));
         check($sformatf("v%0d_wordcount", i), 32'(bus.WordCount), 32'(vecs[i].len));
         check($sformatf("v%0d_error", i), 32'(bus.Error), 32'd0);
         check($sformatf("v%0d_busy", i), 32'(bus.Busy), 32'd0);
      end

      // Ack stuck low: timeout in REQ after 15 cycles, then Start recovers.
      resp_auto = 1'b0;
      bus.Ack = 1'b0;
      start_burst(4'd2);
      wait_err(40, ok);
      check("req_tmo_seen", 32'(ok), 32'd1);
      check("req_tmo_cycles", 32'(err_cyc - start_cyc), 32'd16);
      check("req_tmo_datarequest", 32'(bus.DataRequest), 32'd0);
      check("req_tmo_busy", 32'(bus.Busy), 32'd0);
      repeat (3) tick();
      check("req_tmo_sticky", 32'(bus.Error), 32'd1);
      resp_q.push_back(8'h11);
      resp_q.push_back(8'h22);
      resp_auto = 1'b1;
      base_done = done_cnt;
      start_burst(4'd2);
      check("recover_error_clear", 32'(bus.Error), 32'd0);
      check("recover_busy", 32'(bus.Busy), 32'd1);
      wait_done(base_done, 100, ok);
      check("recover_done", 32'(ok), 32'd1);
      check("recover_wordcount", 32'(bus.WordCount), 32'd2);

      // Ack stuck high after one capture: timeout in REL; Start ignored until Ack falls.
      resp_auto = 1'b0;
      bus.Ack = 1'b0;
      base_dv = dv_cnt;
      start_burst(4'd3);
      for (int n = 0; n < 10 && bus.DataRequest !== 1'b1; n++) tick();
      check("rel_request_seen", 32'(bus.DataRequest), 32'd1);
      bus.Data = 8'h77;
      sb_q.push_back(8'h77);
      bus.Ack = 1'b1;
      ack_cyc = cyc;
      wait_err(40, ok);
      check("rel_tmo_seen", 32'(ok), 32'd1);
      check("rel_tmo_cycles", 32'(err_cyc - ack_cyc), 32'd16);
      check("rel_tmo_wordcount", 32'(bus.WordCount), 32'd1);
      check("rel_tmo_dv_count", 32'(dv_cnt - base_dv), 32'd1);
      bus.Start = 1'b1;
      bus.BurstLen = 4'd2;
      for (int n = 0; n < 3; n++) begin
         tick();
         check("err_start_ignored_error", 32'(bus.Error), 32'd1);
         check("err_start_ignored_busy", 32'(bus.Busy), 32'd0);
      end
      resp_q.push_back(8'h9C);
      resp_q.push_back(8'hE1);
      base_done = done_cnt;
      bus.Ack = 1'b0;
      resp_auto = 1'b1;
      tick();
      check("err_restart_error", 32'(bus.Error), 32'd0);
      check("err_restart_busy", 32'(bus.Busy), 32'd1);
      check("err_restart_wordcount", 32'(bus.WordCount), 32'd0);
      bus.Start = 1'b0;
      wait_done(base_done, 100, ok);
      check("err_restart_done", 32'(ok), 32'd1);
      check("err_restart_wordcount_end", 32'(bus.WordCount), 32'd2);

      // Reset in the middle of a 4-word burst.
      resp_q.push_back(8'hC3);
      base_done = done_cnt;
      start_burst(4'd4);
      for (int n = 0; n < 20 && bus.WordCount != 4'd1; n++) tick();
      resp_auto = 1'b0;
      bus.Ack = 1'b0;
      repeat (3) tick();
      check("midrst_pre_request", 32'(bus.DataRequest), 32'd1);
      check("midrst_pre_wordcount", 32'(bus.WordCount), 32'd1);
      ResetN = 1'b0;
      tick();
      check("midrst_datarequest", 32'(bus.DataRequest), 32'd0);
      check("midrst_wordcount", 32'(bus.WordCount), 32'd0);
      check("midrst_busy", 32'(bus.Busy), 32'd0);
      check("midrst_dataout", 32'(bus.DataOut), 32'd0);
      ResetN = 1'b1;
      repeat (3) tick();
      check("midrst_no_done", 32'(done_cnt - base_done), 32'd0);
      check("midrst_error", 32'(bus.Error), 32'd0);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
